// File: rtl/ccd_pkg.sv
// ---------------------------------------------------------------------------
// ccd_pkg
//   Shared types and constants for the linear-CCD frame sequencer.
//   - state_e    : frame sequencer states
//   - PX_W       : width of the pixel index driven to the ADC reader
//   - bank_t     : ping-pong frame RAM bank index
//   - is_sh()    : true for the two shift-gate states
// ---------------------------------------------------------------------------
package ccd_pkg;

  localparam int PX_W           = 13;
  localparam int NUM_PIXELS_DEF = 5474;

  typedef logic bank_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SH1,
    ST_INTEG,
    ST_SH2,
    ST_READOUT,
    ST_DONE
  } state_e;

  function automatic logic is_sh(input state_e s);
    return (s == ST_SH1) || (s == ST_SH2);
  endfunction

endpackage

// File: rtl/ccd_pixel_timer.sv
// ---------------------------------------------------------------------------
// ccd_pixel_timer
//   Pixel-period divider shared by integration and readout.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     clr        : hold the divider at 0 (next count is 0)
//     pix_tick   : high in the last clk of each pixel period (divider wrap)
//     clb_win    : high when the count loaded at the next edge is inside the
//                  clamp window 0..CLB_CLKS-1, so a downstream flop lines up
//                  exactly with the divider count
// ---------------------------------------------------------------------------
module ccd_pixel_timer #(
  parameter int CLK_DIV  = 16,
  parameter int CLB_CLKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic pix_tick,
  output logic clb_win
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] CLB_END  = DIV_W'(CLB_CLKS);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    pix_tick = !clr && (div_q == DIV_LAST);
    div_d    = (clr || pix_tick) ? '0 : div_q + 1'b1;
    clb_win  = (div_d < CLB_END);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/ccd_frame_sequencer.sv
// ---------------------------------------------------------------------------
// ccd_frame_sequencer
//   Frame-level controller for the linear-CCD capture path: shift-gate pulse,
//   integration, second shift-gate pulse, gated pixel readout, then hands the
//   filled ping-pong bank to the host.
//   Inputs : clk, rst_n (sync, active-low), start, abort, int_time,
//            bank_release, release_bank
//   Outputs: sh, shoot, clb, pxcount, wr_bank, bank_full, busy, frame_done,
//            overrun -- all straight from flops
// ---------------------------------------------------------------------------
module ccd_frame_sequencer
  import ccd_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int CLB_CLKS   = 4,
  parameter int SH_CLKS    = 32,
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int INT_W      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [INT_W-1:0] int_time,
  input  logic             bank_release,
  input  logic             release_bank,
  output logic             sh,
  output logic             shoot,
  output logic             clb,
  output logic [PX_W-1:0]  pxcount,
  output logic             wr_bank,
  output logic [1:0]       bank_full,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int SH_W = $clog2(SH_CLKS + 1);
  localparam logic [SH_W-1:0] SH_LAST = SH_W'(SH_CLKS - 1);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(NUM_PIXELS - 1);

  state_e           state_q, state_d;
  logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
  logic [INT_W-1:0] int_cnt_q, int_cnt_d;
  logic [INT_W-1:0] int_lat_q, int_lat_d;
  logic [PX_W-1:0]  pxcount_q, pxcount_d;
  bank_t            wr_bank_q, wr_bank_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             overrun_q, overrun_d;
  logic             sh_q, sh_d;
  logic             shoot_q, shoot_d;
  logic             clb_q, clb_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic timer_clr, pix_tick, clb_win;

  // Divider only runs while a phase is counting pixel periods; every entry
  // into INTEG or READOUT therefore begins at count 0.
  assign timer_clr = !((state_q == ST_INTEG) || (state_q == ST_READOUT));

  ccd_pixel_timer #(
    .CLK_DIV  (CLK_DIV),
    .CLB_CLKS (CLB_CLKS)
  ) u_pixel_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .pix_tick (pix_tick),
    .clb_win  (clb_win)
  );

  // NOTE: every signal this block writes gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = '0;
    int_cnt_d   = int_cnt_q;
    int_lat_d   = int_lat_q;
    pxcount_d   = pxcount_q;
    wr_bank_d   = wr_bank_q;
    bank_full_d = bank_full_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        int_cnt_d = '0;
        if (start && !abort) begin
          if (bank_full_q[wr_bank_q]) begin
            overrun_d = 1'b1;
          end else begin
            state_d   = ST_SH1;
            int_lat_d = (int_time == '0) ? INT_W'(1) : int_time;
          end
        end
      end
      ST_SH1, ST_SH2: begin
        if (sh_cnt_q == SH_LAST) state_d = (state_q == ST_SH1) ? ST_INTEG : ST_READOUT;
        else                     sh_cnt_d = sh_cnt_q + 1'b1;
      end
      ST_INTEG: begin
        if (pix_tick) begin
          if (int_cnt_q == int_lat_q - 1'b1) begin
            state_d   = ST_SH2;
            int_cnt_d = '0;
          end else begin
            int_cnt_d = int_cnt_q + 1'b1;
          end
        end
      end
      ST_READOUT: begin
        // The last wrap lands on NUM_PIXELS and the count then holds there.
        if (pix_tick) begin
          pxcount_d = pxcount_q + 1'b1;
          if (pxcount_q == PX_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_SH2 && state_d == ST_READOUT) pxcount_d = '0;

    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;

    // Clear first, set second: a release hitting the bank that is being
    // filled this cycle loses.
    if (bank_release) bank_full_d[release_bank] = 1'b0;
    if (state_d == ST_DONE) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    sh_d         = is_sh(state_d);
    shoot_d      = (state_d == ST_READOUT);
    clb_d        = (state_d == ST_READOUT) && clb_win;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sh_cnt_q     <= '0;
      int_cnt_q    <= '0;
      int_lat_q    <= '0;
      pxcount_q    <= '0;
      wr_bank_q    <= 1'b0;
      bank_full_q  <= '0;
      overrun_q    <= 1'b0;
      sh_q         <= 1'b0;
      shoot_q      <= 1'b0;
      clb_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      int_cnt_q    <= int_cnt_d;
      int_lat_q    <= int_lat_d;
      pxcount_q    <= pxcount_d;
      wr_bank_q    <= wr_bank_d;
      bank_full_q  <= bank_full_d;
      overrun_q    <= overrun_d;
      sh_q         <= sh_d;
      shoot_q      <= shoot_d;
      clb_q        <= clb_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sh         = sh_q;
  assign shoot      = shoot_q;
  assign clb        = clb_q;
  assign pxcount    = pxcount_q;
  assign wr_bank    = wr_bank_q;
  assign bank_full  = bank_full_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ccd_frame_sequencer
//   Scoreboard bench: the driver pushes the expected outcome of each frame
//   (phase lengths, clamp pulse count, bank state) and a negedge monitor
//   measures the frame and compares when busy falls. Small parameters keep
//   frames short.
// ---------------------------------------------------------------------------
module tb_ccd_frame_sequencer;

  localparam int DIV = 8;
  localparam int CLB = 3;
  localparam int SHC = 5;
  localparam int NP  = 12;
  localparam int IW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [IW-1:0] int_time = '0;
  logic          bank_release = 1'b0;
  logic          release_bank = 1'b0;
  logic          sh, shoot, clb, wr_bank, busy, frame_done, overrun;
  logic [12:0]   pxcount;
  logic [1:0]    bank_full;

  always #5 clk = ~clk;

  ccd_frame_sequencer #(
    .CLK_DIV    (DIV),
    .CLB_CLKS   (CLB),
    .SH_CLKS    (SHC),
    .NUM_PIXELS (NP),
    .INT_W      (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .int_time     (int_time),
    .bank_release (bank_release),
    .release_bank (release_bank),
    .sh           (sh),
    .shoot        (shoot),
    .clb          (clb),
    .pxcount      (pxcount),
    .wr_bank      (wr_bank),
    .bank_full    (bank_full),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one busy period.
  typedef struct {
    bit         full;      // completed frame: check lengths and pulses
    bit         done;      // frame_done pulse expected
    int         busy_len;
    int         sh_len;
    int         integ_len;
    int         clb_n;
    logic [1:0] bf;
    logic       wb;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of the bank/overrun state.
  logic [1:0] bf_m = 2'b00;
  logic       wb_m = 1'b0;
  logic       ov_m = 1'b0;

  function automatic exp_t frame_exp(input int t);
    exp_t e;
    e.full      = 1'b1;
    e.done      = 1'b1;
    e.sh_len    = 2 * SHC;
    e.integ_len = ((t == 0) ? 1 : t) * DIV;
    e.clb_n     = NP;
    e.busy_len  = e.sh_len + e.integ_len + NP * DIV + 1;
    e.bf        = bf_m | (2'b01 << wb_m);
    e.wb        = ~wb_m;
    return e;
  endfunction

  function automatic exp_t cut_exp(input logic [1:0] bf, input logic wb);
    exp_t e;
    e.full = 1'b0; e.done = 1'b0; e.busy_len = 0; e.sh_len = 0;
    e.integ_len = 0; e.clb_n = 0; e.bf = bf; e.wb = wb;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int          busy_cnt = 0, sh_cnt = 0, integ_cnt = 0, clb_n = 0, clb_w = 0, done_cnt = 0;
  logic        p_busy = 1'b0, p_clb = 1'b0, p_shoot = 1'b0;
  logic [12:0] p_px = '0;

  always @(negedge clk) begin
    exp_t e;
    if (busy && !p_busy) begin
      busy_cnt = 0; sh_cnt = 0; integ_cnt = 0; clb_n = 0; done_cnt = 0;
    end
    if (busy) begin
      busy_cnt++;
      if (sh) sh_cnt++;
      if (!sh && !shoot && !frame_done) integ_cnt++;
      if (frame_done) begin
        done_cnt++;
        check("px_at_done", 32'(pxcount), 32'(NP));
      end
    end
    if (clb && !p_clb) begin
      clb_n++;
      clb_w = 1;
      check("px_at_clb_rise", 32'(pxcount), 32'(clb_n - 1));
    end else if (clb) begin
      clb_w++;
    end
    if (p_clb && !clb && shoot) check("clb_width", 32'(clb_w), 32'(CLB));
    if (shoot && p_shoot && pxcount != p_px) check("px_change_on_clb_rise", 32'(clb && !p_clb), 32'd1);
    if (p_busy && !busy) begin
      check("frame_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("frame_done_count", 32'(done_cnt), 32'(e.done));
        check("bank_full_after", 32'(bank_full), 32'(e.bf));
        check("wr_bank_after", 32'(wr_bank), 32'(e.wb));
        if (e.full) begin
          check("frame_len", 32'(busy_cnt), 32'(e.busy_len));
          check("sh_len", 32'(sh_cnt), 32'(e.sh_len));
          check("integ_len", 32'(integ_cnt), 32'(e.integ_len));
          check("clb_pulses", 32'(clb_n), 32'(e.clb_n));
        end
      end
    end
    p_busy = busy; p_clb = clb; p_shoot = shoot; p_px = pxcount;
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input int t, input bit rel_at_done);
    exp_t e;
    e = frame_exp(t);
    exp_q.push_back(e);
    @(negedge clk); start = 1'b1; int_time = IW'(t);
    @(negedge clk); start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_sh", 32'(sh), 32'd1);
    if (rel_at_done) begin
      // Release the bank being filled on the edge that enters DONE.
      repeat (e.busy_len - 2) @(negedge clk);
      bank_release = 1'b1; release_bank = wb_m;
      @(negedge clk); bank_release = 1'b0;
    end
    wait_idle();
    bf_m = e.bf; wb_m = e.wb;
  endtask

  task automatic rel_bank(input logic b);
    @(negedge clk); bank_release = 1'b1; release_bank = b;
    @(negedge clk); bank_release = 1'b0;
    bf_m[b] = 1'b0;
    check("release_bank_full", 32'(bank_full), 32'(bf_m));
  endtask

  task automatic refused_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ov_m = 1'b1;
    check("refused_busy", 32'(busy), 32'd0);
    check("refused_overrun", 32'(overrun), 32'(ov_m));
    check("refused_bank_full", 32'(bank_full), 32'(bf_m));
  endtask

  task automatic two_frames_held(input int t);
    exp_t e1, e2;
    int   gap = 0;
    e1 = frame_exp(t); exp_q.push_back(e1); bf_m = e1.bf; wb_m = e1.wb;
    e2 = frame_exp(t); exp_q.push_back(e2);
    @(negedge clk); start = 1'b1; int_time = IW'(t);
    @(negedge clk);
    wait_idle();
    while (!busy && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    start = 1'b0;
    check("back_to_back_idle_gap", 32'(gap), 32'd1);
    wait_idle();
    bf_m = e2.bf; wb_m = e2.wb;
    check("pingpong_bank_full", 32'(bank_full), 32'(bf_m));
  endtask

  task automatic abort_frame(input int t, input int at_px);
    int n = 0;
    exp_q.push_back(cut_exp(bf_m, wb_m));
    @(negedge clk); start = 1'b1; int_time = IW'(t);
    @(negedge clk); start = 1'b0;
    while (!(shoot && pxcount == 13'(at_px)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("abort_point_reached", 32'(pxcount), 32'(at_px));
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_shoot", 32'(shoot), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_clb", 32'(clb), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sh"}, 32'(sh), 32'd0);
    check({tag, "_shoot"}, 32'(shoot), 32'd0);
    check({tag, "_clb"}, 32'(clb), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_pxcount"}, 32'(pxcount), 32'd0);
    check({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
    check({tag, "_bank_full"}, 32'(bank_full), 32'd0);
  endtask

  initial begin
    // Reset, then a single frame.
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    run_frame(10, 1'b0);
    check("single_bank_full", 32'(bank_full), 32'b01);
    check("single_wr_bank", 32'(wr_bank), 32'd1);

    // Ping-pong: two back-to-back frames with no release, then a refused start.
    rel_bank(1'b0);
    two_frames_held(3);
    refused_start();
    rel_bank(wb_m);
    run_frame(0, 1'b0);

    // start and abort together in IDLE: nothing starts.
    rel_bank(1'b0);
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_overrun", 32'(overrun), 32'(ov_m));

    // Abort mid-readout, then a DONE-set racing a release of the same bank.
    abort_frame(2, 5);
    run_frame(2, 1'b1);
    check("set_beats_release", 32'(bank_full[~wb_m]), 32'd1);

    // Reset during integration, then a clean frame.
    rel_bank(1'b0);
    rel_bank(1'b1);
    exp_q.push_back(cut_exp(2'b00, 1'b0));
    @(negedge clk); start = 1'b1; int_time = IW'(4);
    @(negedge clk); start = 1'b0;
    repeat (SHC + 10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset");
    bf_m = 2'b00; wb_m = 1'b0; ov_m = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_frame(2, 1'b0);

    // Randomised traffic against the bank model.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0) rel_bank(1'($urandom_range(0, 1)));
      if (bf_m[wb_m]) refused_start();
      else            run_frame(int'($urandom_range(0, 5)), $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
